qa_driver_mmio_rsp_arb: RTL and testbench
=========================================

# qa_driver_mmio_rsp_arb

Shares the single MMIO read-response channel (c2Tx) among several independent response producers: local CSR reads, SREG responses and additional feature CSR blocks. Each producer has a one-entry holding slot. A round-robin scheduler drains the slots into a registered c2Tx output, one response per cycle. Overflow on a busy slot is dropped and flagged for debug.

## Interface
Parameters:
- N_REQ, 4, number of response producers (2..8)
- TID_WIDTH, 9, width of the MMIO transaction ID
- DATA_WIDTH, 64, width of the MMIO read data

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-producer response strobe, one cycle per response
- req_tid  in  N_REQ x TID_WIDTH  per-producer TID
- req_data  in  N_REQ x DATA_WIDTH  per-producer read data
- req_full  out  N_REQ  slot i occupied (registered)
- rsp_valid  out  1  drives c2Tx.mmioRdValid
- rsp_tid  out  TID_WIDTH  drives c2Tx.hdr.tid
- rsp_data  out  DATA_WIDTH  drives c2Tx.data
- drop_err  out  1  sticky: at least one response has been dropped
- drop_count  out  16  saturating count of dropped responses

## Operation
- Slot i holds {tid, data} and an occupied bit.
- Arbiter: each cycle, among occupied slots, grant the first index found searching upward from last_grant+1 mod N_REQ. At most one grant per cycle. last_grant updates only on a grant.
- Grant: the output register loads the slot's tid/data with rsp_valid=1, and the slot's occupied bit clears. With no grant, rsp_valid=0 next cycle and rsp_tid/rsp_data hold their values.
- Request acceptance: req_valid[i] is accepted if slot i is empty, or if slot i is granted in the same cycle (simultaneous free and refill). The slot loads at the clock edge and ends occupied.
- Drop: req_valid[i] while slot i is occupied and not granted that cycle. The slot keeps its old contents. drop_err sets. drop_count increments and saturates at 0xFFFF.
- Several drops in one cycle: drop_count increments by the number of drops, saturating.
- No backpressure from the FIU exists. The output is never stalled.

## Timing
- Reset values: rsp_valid=0, rsp_tid=0, rsp_data=0, req_full=0, all slots empty, drop_err=0, drop_count=0, last_grant=N_REQ-1, so port 0 wins first.
- Latency: request in cycle t, slot occupied in t+1, and with no contention rsp_valid=1 in t+2. Minimum latency is 2 cycles.
- Worst-case latency with all slots busy: 2 + (N_REQ-1) cycles.
- Throughput: one response per cycle sustained. A single producer may issue every cycle without drops, because grant and refill happen together.
- req_full[i] reflects the slot state at the start of the cycle. Producers must not rely on it to avoid the refill-on-grant case.
- Reset mid-operation: all occupied slots are discarded without being emitted. rsp_valid=0 in the cycle after reset is sampled. Requests presented during reset are ignored and do not count as drops.
- Wrap-around: the search pointer wraps from N_REQ-1 to 0.

## Test plan
- Single response: req_valid[2]=1, tid=0x15, data=0xDEAD_BEEF_0000_0001 at cycle 5 -> rsp_valid=1, rsp_tid=0x15, rsp_data=0xDEAD_BEEF_0000_0001 in cycle 7 only; req_full[2]=1 in cycle 6 only.
- Simultaneous burst after reset: all four ports valid in one cycle with tids 0x10..0x13 -> responses on four consecutive cycles with tids 0x10, 0x11, 0x12, 0x13; no drops.
- Round-robin fairness: after a grant to port 1, ports 0 and 3 both pending -> port 3 is granted before port 0.
- Overflow: port 0 valid tid 0x01, then valid tid 0x02 in the next cycle while port 3 is granted that cycle -> tid 0x02 is dropped, drop_err=1, drop_count=1; only 0x01 is emitted from port 0.
- Back-to-back single producer: port 1 valid for 8 consecutive cycles with tids 0..7 -> 8 consecutive rsp_valid cycles with tids 0..7 and drop_count=0.
- Reset mid-operation: 3 slots occupied, reset asserted for 1 cycle -> no rsp_valid afterward, req_full=0, drop_count=0; a new request 2 cycles later is emitted normally with port 0 priority restored.

Source files
------------

// File: rtl/qa_driver_mmio_rsp_arb.sv
// Round-robin arbiter sharing the MMIO read-response channel among N_REQ producers.
// Each producer owns a one-entry slot; overflow on a busy, ungranted slot is dropped and counted.
module qa_driver_mmio_rsp_arb #(
  parameter int N_REQ      = 4,
  parameter int TID_WIDTH  = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_REQ-1:0]                      req_valid,
  input  logic [N_REQ-1:0][TID_WIDTH-1:0]       req_tid,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_data,
  output logic [N_REQ-1:0]                      req_full,
  output logic                                  rsp_valid,
  output logic [TID_WIDTH-1:0]                  rsp_tid,
  output logic [DATA_WIDTH-1:0]                 rsp_data,
  output logic                                  drop_err,
  output logic [15:0]                           drop_count
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(N_REQ + 1);

  logic [N_REQ-1:0]      slot_full;
  logic [TID_WIDTH-1:0]  slot_tid  [N_REQ];
  logic [DATA_WIDTH-1:0] slot_data [N_REQ];
  logic [IDX_W-1:0]      last_grant;

  logic                  grant_vld;
  logic [IDX_W-1:0]      grant_idx;
  logic [N_REQ-1:0]      grant_oh;
  logic [N_REQ-1:0]      accept;
  logic [N_REQ-1:0]      drop;
  logic [CNT_W-1:0]      drop_num;
  logic [16:0]           drop_sum;

  // Search upward from the slot after the last winner, wrapping at N_REQ.
  always_comb begin
    int p;
    p         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      p = int'(last_grant) + k;
      if (p >= N_REQ) p = p - N_REQ;
      if (!grant_vld && slot_full[IDX_W'(p)]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(p);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  // A slot being drained this cycle can be refilled in the same edge.
  assign accept = req_valid & (~slot_full | grant_oh);
  assign drop   = req_valid & slot_full & ~grant_oh;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < N_REQ; i++) begin
      drop_num = drop_num + CNT_W'(drop[i]);
    end
    drop_sum = {1'b0, drop_count} + 17'(drop_num);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full  <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_tid    <= '0;
      rsp_data   <= '0;
      drop_err   <= 1'b0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i])        slot_full[i] <= 1'b1;
        else if (grant_oh[i]) slot_full[i] <= 1'b0;
      end
      rsp_valid <= grant_vld;
      if (grant_vld) begin
        rsp_tid    <= slot_tid[grant_idx];
        rsp_data   <= slot_data[grant_idx];
        last_grant <= grant_idx;
      end
      if (|drop) drop_err <= 1'b1;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Payload needs no reset: it is only observed behind slot_full.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (!reset && accept[i]) begin
        slot_tid[i]  <= req_tid[i];
        slot_data[i] <= req_data[i];
      end
    end
  end

  assign req_full = slot_full;

endmodule

// File: tb/tb_qa_driver_mmio_rsp_arb.sv
// Bench for qa_driver_mmio_rsp_arb: directed scenarios plus random traffic and drop-count
// saturation, all checked every cycle against a slot/queue reference model.
module tb_qa_driver_mmio_rsp_arb;

  localparam int N    = 4;
  localparam int TW   = 9;
  localparam int DW   = 64;

  logic                    clk;
  logic                    reset;
  logic [N-1:0]            req_valid;
  logic [N-1:0][TW-1:0]    req_tid;
  logic [N-1:0][DW-1:0]    req_data;
  logic [N-1:0]            req_full;
  logic                    rsp_valid;
  logic [TW-1:0]           rsp_tid;
  logic [DW-1:0]           rsp_data;
  logic                    drop_err;
  logic [15:0]             drop_count;

  qa_driver_mmio_rsp_arb #(.N_REQ(N), .TID_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_tid    (req_tid),
    .req_data   (req_data),
    .req_full   (req_full),
    .rsp_valid  (rsp_valid),
    .rsp_tid    (rsp_tid),
    .rsp_data   (rsp_data),
    .drop_err   (drop_err),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupancy flags and payloads per producer, plus the expected output register.
  bit          m_full [N];
  logic [TW-1:0] m_tid [N];
  logic [DW-1:0] m_data [N];
  int          m_last;
  bit          m_rsp_valid;
  logic [TW-1:0] m_rsp_tid;
  logic [DW-1:0] m_rsp_data;
  bit          m_drop_err;
  int          m_drop_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int g;
    int nd;
    if (reset) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_last       = N - 1;
      m_rsp_valid  = 1'b0;
      m_rsp_tid    = '0;
      m_rsp_data   = '0;
      m_drop_err   = 1'b0;
      m_drop_count = 0;
      return;
    end
    g = -1;
    for (int k = 1; k <= N; k++) begin
      if (g < 0 && m_full[(m_last + k) % N]) g = (m_last + k) % N;
    end
    if (g >= 0) begin
      m_rsp_valid = 1'b1;
      m_rsp_tid   = m_tid[g];
      m_rsp_data  = m_data[g];
      m_full[g]   = 1'b0;
      m_last      = g;
    end else begin
      m_rsp_valid = 1'b0;
    end
    nd = 0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        if (m_full[i]) nd++;
        else begin
          m_full[i] = 1'b1;
          m_tid[i]  = req_tid[i];
          m_data[i] = req_data[i];
        end
      end
    end
    if (nd > 0) m_drop_err = 1'b1;
    m_drop_count = (m_drop_count + nd > 65535) ? 65535 : m_drop_count + nd;
  endtask

  task automatic tick();
    logic [N-1:0] ef;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) ef[i] = m_full[i];
    chk("rsp_valid",  64'(rsp_valid),  64'(m_rsp_valid));
    chk("rsp_tid",    64'(rsp_tid),    64'(m_rsp_tid));
    chk("rsp_data",   rsp_data,        m_rsp_data);
    chk("req_full",   64'(req_full),   64'(ef));
    chk("drop_err",   64'(drop_err),   64'(m_drop_err));
    chk("drop_count", 64'(drop_count), 64'(m_drop_count));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_tid   = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_tid[i]  = '0;
      m_data[i] = '0;
    end
    m_last = N - 1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_req_full",  64'(req_full),  64'd0);

    // Single response: full one cycle, emitted the next, once.
    req_valid = 4'b0100;
    req_tid[2]  = 9'h15;
    req_data[2] = 64'hDEAD_BEEF_0000_0001;
    tick();
    req_valid = '0;
    chk("t1_full",     64'(req_full),  64'h4);
    chk("t1_early",    64'(rsp_valid), 64'd0);
    tick();
    chk("t1_valid",    64'(rsp_valid), 64'd1);
    chk("t1_tid",      64'(rsp_tid),   64'h15);
    chk("t1_data",     rsp_data,       64'hDEAD_BEEF_0000_0001);
    chk("t1_empty",    64'(req_full),  64'd0);
    tick();
    chk("t1_once",     64'(rsp_valid), 64'd0);

    // Simultaneous burst after reset drains in port order.
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) req_tid[i] = TW'(9'h10 + i);
    tick();
    req_valid = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      chk("t2_valid", 64'(rsp_valid), 64'd1);
      chk("t2_tid",   64'(rsp_tid),   64'(9'h10 + k));
    end
    chk("t2_drops", 64'(drop_count), 64'd0);

    // Fairness: after port 1 wins, port 3 precedes port 0.
    do_reset();
    req_valid = 4'b0010; req_tid[1] = 9'h21;
    tick();
    req_valid = 4'b1001; req_tid[0] = 9'h20; req_tid[3] = 9'h23;
    tick();
    req_valid = '0;
    chk("t3_first",  64'(rsp_tid), 64'h21);
    tick();
    chk("t3_second", 64'(rsp_tid), 64'h23);
    tick();
    chk("t3_third",  64'(rsp_tid), 64'h20);

    // Overflow on port 0 while port 3 is granted.
    do_reset();
    req_valid = 4'b0100; req_tid[2] = 9'h32;
    tick();
    req_valid = 4'b1001; req_tid[3] = 9'h33; req_tid[0] = 9'h01;
    tick();
    req_valid = 4'b0001; req_tid[0] = 9'h02;
    tick();
    req_valid = '0;
    chk("t4_grant3", 64'(rsp_tid),    64'h33);
    chk("t4_err",    64'(drop_err),   64'd1);
    chk("t4_count",  64'(drop_count), 64'd1);
    tick();
    chk("t4_port0",  64'(rsp_tid),    64'h01);
    tick();
    chk("t4_no_02",  64'(rsp_valid),  64'd0);

    // Back-to-back single producer.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        req_valid = 4'b0010;
        req_tid[1] = TW'(k);
      end else begin
        req_valid = '0;
      end
      tick();
      if (k >= 1 && k <= 8) begin
        chk("t5_valid", 64'(rsp_valid), 64'd1);
        chk("t5_tid",   64'(rsp_tid),   64'(k - 1));
      end
    end
    chk("t5_drops", 64'(drop_count), 64'd0);

    // Reset mid-operation discards slots and ignores requests presented during reset.
    do_reset();
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) req_tid[i] = TW'(9'h50 + i);
    tick();
    chk("t6_filled", 64'(req_full), 64'h7);
    reset = 1'b1;
    req_valid = 4'b1000; req_tid[3] = 9'h5F;
    tick();
    reset = 1'b0;
    req_valid = '0;
    chk("t6_valid",  64'(rsp_valid),  64'd0);
    chk("t6_full",   64'(req_full),   64'd0);
    chk("t6_drops",  64'(drop_count), 64'd0);
    tick();
    chk("t6_quiet",  64'(rsp_valid),  64'd0);
    req_valid = 4'b1001; req_tid[0] = 9'h40; req_tid[3] = 9'h43;
    tick();
    req_valid = '0;
    tick();
    chk("t6_port0",  64'(rsp_tid), 64'h40);
    tick();
    chk("t6_port3",  64'(rsp_tid), 64'h43);

    // Random traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 35);
        req_tid[i]   = TW'($urandom);
        req_data[i]  = {$urandom, $urandom};
      end
      tick();
    end
    reset = 1'b0;

    // Saturate drop_count: every port strobes every cycle, three drops per cycle.
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 22000; c++) begin
      for (int i = 0; i < N; i++) req_tid[i] = TW'($urandom);
      tick();
    end
    req_valid = '0;
    chk("sat_count", 64'(drop_count), 64'hFFFF);
    chk("sat_err",   64'(drop_err),   64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
